// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: control-bit positions, memory FSM states
// and the pipeline register layouts used by the memory-access stage.
package mips_pkg;

    localparam int MEM_READ        = 0;
    localparam int MEM_WRITE       = 1;
    localparam int MEM_BRANCH      = 2;
    localparam int WB_REGWRITE     = 0;
    localparam int WB_MEMTOREG     = 1;
    localparam int DEFAULT_TIMEOUT = 15;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } memState_e;

    // The reserved MEM bit 3 is dropped, so only three MEM control bits are kept.
    typedef struct packed {
        logic [31:0] result;
        logic [31:0] outB;
        logic [4:0]  writeReg;
        logic [2:0]  mem;
        logic [1:0]  wb;
        logic [31:0] target;
        logic        equal;
    } exMem_t;

    typedef struct packed {
        logic        regWrite;
        logic [4:0]  writeReg;
        logic [31:0] value;
    } memWb_t;

endpackage

// File: rtl/dmem_if.sv
// Data-memory handshake controller: request FSM, bounded wait counter,
// and the stall/abort/done strobes for the memory stage.
module dmem_if
    import mips_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic access_i,
    input  logic ready_i,
    output logic req_o,
    output logic stall_o,
    output logic abort_o,
    output logic done_o
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    memState_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The request goes out in IDLE already, so a memory that answers at once costs no stall.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_o   = 1'b0;
        abort_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access_i) begin
                    req_o = 1'b1;
                    if (!ready_i) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            S_WAIT: begin
                req_o = 1'b1;
                if (ready_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == LIMIT) begin
                    abort_o = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign done_o  = req_o & ready_i;
    assign stall_o = access_i & ~done_o & ~abort_o;

endmodule

// File: rtl/stage4.sv
// MIPS memory-access stage: EX/MEM and MEM/WB pipeline registers, beq resolution,
// forwarding taps and the variable-latency data-memory interface.
module stage4
    import mips_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Result,
    input  logic [31:0] OutB,
    input  logic [4:0]  WriteReg,
    input  logic [3:0]  MEMReg,
    input  logic [1:0]  WBReg,
    input  logic [31:0] PCPlus4PlusOff,
    input  logic        Equal,
    input  logic        Flush,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        Stall,
    output logic [31:0] ALUop_inMEM,
    output logic        RegWrite_inMEM,
    output logic [4:0]  WriteReg_inMEM,
    output logic        PCSrc,
    output logic [31:0] BranchTarget,
    output logic [31:0] MUXop_inWB,
    output logic        RegWrite_inWB,
    output logic [4:0]  WriteReg_inWB,
    output logic        MemErr
);

    exMem_t exMem_q, exMem_d;
    memWb_t memWb_q, memWb_d;
    logic   memErr_q, memErr_d;

    logic        memop, misaligned, access;
    logic        req, stall, abort, done;
    logic [31:0] loadData;
    logic        unusedMemBit;

    assign unusedMemBit = MEMReg[3];

    assign memop      = exMem_q.mem[MEM_READ] | exMem_q.mem[MEM_WRITE];
    assign misaligned = memop & (exMem_q.result[1:0] != 2'b00);
    assign access     = memop & ~misaligned;

    dmem_if #(.TIMEOUT(TIMEOUT)) u_dmem_if (
        .clk      (clk),
        .reset    (reset),
        .access_i (access),
        .ready_i  (dmem_ready),
        .req_o    (req),
        .stall_o  (stall),
        .abort_o  (abort),
        .done_o   (done)
    );

    // Aborted and misaligned loads both fall through to a zero load value.
    assign loadData = done ? dmem_rdata : 32'h0;

    always_comb begin
        exMem_d = exMem_q;
        if (!stall) begin
            exMem_d.result   = Result;
            exMem_d.outB     = OutB;
            exMem_d.writeReg = WriteReg;
            exMem_d.mem      = MEMReg[2:0];
            exMem_d.wb       = WBReg;
            exMem_d.target   = PCPlus4PlusOff;
            exMem_d.equal    = Equal;
            if (Flush) begin
                exMem_d.mem = '0;
                exMem_d.wb  = '0;
            end
        end
        memWb_d.regWrite = exMem_q.wb[WB_REGWRITE] & ~stall;
        memWb_d.writeReg = exMem_q.writeReg;
        memWb_d.value    = exMem_q.wb[WB_MEMTOREG] ? loadData : exMem_q.result;
        memErr_d         = memErr_q | misaligned | abort;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exMem_q  <= '0;
            memWb_q  <= '0;
            memErr_q <= 1'b0;
        end else begin
            exMem_q  <= exMem_d;
            memWb_q  <= memWb_d;
            memErr_q <= memErr_d;
        end
    end

    assign dmem_req       = req;
    assign dmem_we        = req & exMem_q.mem[MEM_WRITE];
    assign dmem_addr      = exMem_q.result;
    assign dmem_wdata     = exMem_q.outB;
    assign Stall          = stall;
    assign ALUop_inMEM    = exMem_q.result;
    assign RegWrite_inMEM = exMem_q.wb[WB_REGWRITE];
    assign WriteReg_inMEM = exMem_q.writeReg;
    assign PCSrc          = exMem_q.mem[MEM_BRANCH] & exMem_q.equal;
    assign BranchTarget   = exMem_q.target;
    assign MUXop_inWB     = memWb_q.value;
    assign RegWrite_inWB  = memWb_q.regWrite;
    assign WriteReg_inWB  = memWb_q.writeReg;
    assign MemErr         = memErr_q;

endmodule

// File: tb/tb_stage4.sv
// Directed bench for stage4: expected writebacks are queued when an instruction
// enters EX and popped whenever MEM/WB reports a register write.
module tb_stage4;

    logic        clk, reset;
    logic [31:0] Result, OutB, PCPlus4PlusOff, dmem_rdata;
    logic [4:0]  WriteReg;
    logic [3:0]  MEMReg;
    logic [1:0]  WBReg;
    logic        Equal, Flush, dmem_ready;
    logic        dmem_req, dmem_we, Stall, RegWrite_inMEM, PCSrc, RegWrite_inWB, MemErr;
    logic [31:0] dmem_addr, dmem_wdata, ALUop_inMEM, BranchTarget, MUXop_inWB;
    logic [4:0]  WriteReg_inMEM, WriteReg_inWB;

    typedef struct {
        logic [4:0]  wreg;
        logic [31:0] data;
    } wbExp_t;

    wbExp_t sbQ[$];
    int checks = 0;
    int errors = 0;

    stage4 #(.TIMEOUT(15)) dut (
        .clk            (clk),
        .reset          (reset),
        .Result         (Result),
        .OutB           (OutB),
        .WriteReg       (WriteReg),
        .MEMReg         (MEMReg),
        .WBReg          (WBReg),
        .PCPlus4PlusOff (PCPlus4PlusOff),
        .Equal          (Equal),
        .Flush          (Flush),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_rdata     (dmem_rdata),
        .dmem_ready     (dmem_ready),
        .Stall          (Stall),
        .ALUop_inMEM    (ALUop_inMEM),
        .RegWrite_inMEM (RegWrite_inMEM),
        .WriteReg_inMEM (WriteReg_inMEM),
        .PCSrc          (PCSrc),
        .BranchTarget   (BranchTarget),
        .MUXop_inWB     (MUXop_inWB),
        .RegWrite_inWB  (RegWrite_inWB),
        .WriteReg_inWB  (WriteReg_inWB),
        .MemErr         (MemErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] res, input logic [31:0] b, input logic [4:0] wr,
                                 input logic [3:0] mem, input logic [1:0] wb, input logic [31:0] tgt,
                                 input logic eq, input logic fl);
        Result         = res;
        OutB           = b;
        WriteReg       = wr;
        MEMReg         = mem;
        WBReg          = wb;
        PCPlus4PlusOff = tgt;
        Equal          = eq;
        Flush          = fl;
    endtask

    task automatic applyNop();
        applyStimulus(32'h0, 32'h0, 5'd0, 4'b0000, 2'b00, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic expectWb(input logic [4:0] wr, input logic [31:0] d);
        wbExp_t e;
        e.wreg = wr;
        e.data = d;
        sbQ.push_back(e);
    endtask

    // Advance one clock and retire any writeback against the scoreboard.
    task automatic tick();
        wbExp_t e;
        @(posedge clk);
        #1;
        if (RegWrite_inWB === 1'b1) begin
            if (sbQ.size() == 0) begin
                checkOutput("wb unexpected", RegWrite_inWB, 0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("wb reg", WriteReg_inWB, e.wreg);
                checkOutput("wb data", MUXop_inWB, e.data);
            end
        end
    endtask

    initial begin
        int stallCount;
        int cyc;

        reset      = 1'b1;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        applyStimulus(32'h20, 32'h1234, 5'd4, 4'b0010, 2'b01, 32'h99, 1'b1, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        applyNop();
        #1;
        checkOutput("reset req", dmem_req, 0);
        checkOutput("reset stall", Stall, 0);
        checkOutput("reset aluop", ALUop_inMEM, 0);
        checkOutput("reset regwrite mem", RegWrite_inMEM, 0);
        checkOutput("reset regwrite wb", RegWrite_inWB, 0);
        checkOutput("reset memerr", MemErr, 0);
        checkOutput("reset pcsrc", PCSrc, 0);
        checkOutput("reset muxop", MUXop_inWB, 0);
        tick();

        $display("[TB] ALU forwarding");
        applyStimulus(32'h55, 32'h0, 5'd3, 4'b0000, 2'b01, 32'h0, 1'b0, 1'b0);
        expectWb(5'd3, 32'h55);
        tick();
        applyNop();
        #1;
        checkOutput("fwd aluop", ALUop_inMEM, 32'h55);
        checkOutput("fwd regwrite", RegWrite_inMEM, 1);
        checkOutput("fwd writereg", WriteReg_inMEM, 3);
        tick();

        $display("[TB] load zero-wait");
        applyStimulus(32'h10, 32'h0, 5'd5, 4'b0001, 2'b11, 32'h0, 1'b0, 1'b0);
        expectWb(5'd5, 32'hDEADBEEF);
        tick();
        applyNop();
        dmem_rdata = 32'hDEADBEEF;
        dmem_ready = 1'b1;
        #1;
        checkOutput("lw0 req", dmem_req, 1);
        checkOutput("lw0 we", dmem_we, 0);
        checkOutput("lw0 addr", dmem_addr, 32'h10);
        checkOutput("lw0 stall", Stall, 0);
        tick();
        checkOutput("lw0 wb regwrite", RegWrite_inWB, 1);
        dmem_ready = 1'b0;
        tick();

        $display("[TB] store 3-cycle wait");
        applyStimulus(32'h20, 32'h1234, 5'd0, 4'b0010, 2'b00, 32'h0, 1'b0, 1'b0);
        tick();
        applyStimulus(32'h77, 32'h0, 5'd7, 4'b0000, 2'b01, 32'h0, 1'b0, 1'b0);
        expectWb(5'd7, 32'h77);
        stallCount = 0;
        for (int k = 0; k < 4; k++) begin
            dmem_ready = (k == 3);
            #1;
            checkOutput("sw req", dmem_req, 1);
            checkOutput("sw we", dmem_we, 1);
            checkOutput("sw addr", dmem_addr, 32'h20);
            checkOutput("sw wdata", dmem_wdata, 32'h1234);
            if (Stall === 1'b1) stallCount++;
            tick();
            if (k < 3) checkOutput("sw bubble", RegWrite_inWB, 0);
        end
        checkOutput("sw stall cycles", stallCount, 3);
        applyNop();
        dmem_ready = 1'b0;
        #1;
        checkOutput("sw req released", dmem_req, 0);
        checkOutput("sw held alu advanced", ALUop_inMEM, 32'h77);
        tick();
        tick();

        $display("[TB] load timeout");
        applyStimulus(32'h30, 32'h0, 5'd8, 4'b0001, 2'b11, 32'h0, 1'b0, 1'b0);
        expectWb(5'd8, 32'h0);
        tick();
        applyNop();
        dmem_rdata = 32'hCAFEF00D;
        dmem_ready = 1'b0;
        #1;
        checkOutput("to stall start", Stall, 1);
        cyc = 0;
        while (Stall === 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        checkOutput("to bounded", (cyc < 40), 1);
        checkOutput("to not early", (cyc >= 15), 1);
        checkOutput("to req at abort", dmem_req, 1);
        checkOutput("to memerr before edge", MemErr, 0);
        tick();
        checkOutput("to memerr", MemErr, 1);
        checkOutput("to req dropped", dmem_req, 0);
        tick();

        $display("[TB] reset mid-wait");
        applyStimulus(32'h40, 32'hAA, 5'd6, 4'b0010, 2'b00, 32'h0, 1'b0, 1'b0);
        tick();
        applyNop();
        tick();
        tick();
        checkOutput("rst in wait stall", Stall, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checkOutput("rst req", dmem_req, 0);
        checkOutput("rst stall", Stall, 0);
        checkOutput("rst we", dmem_we, 0);
        checkOutput("rst addr", dmem_addr, 0);
        checkOutput("rst memerr", MemErr, 0);
        dmem_ready = 1'b1;
        #1;
        checkOutput("rst late ready req", dmem_req, 0);
        tick();
        dmem_ready = 1'b0;
        checkOutput("rst late ready wb", RegWrite_inWB, 0);
        checkOutput("rst late ready memerr", MemErr, 0);

        $display("[TB] misaligned load");
        dmem_rdata = 32'h99999999;
        applyStimulus(32'h22, 32'h0, 5'd9, 4'b0001, 2'b11, 32'h0, 1'b0, 1'b0);
        expectWb(5'd9, 32'h0);
        tick();
        applyStimulus(32'h23, 32'h5555, 5'd0, 4'b0010, 2'b00, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("mis req", dmem_req, 0);
        checkOutput("mis stall", Stall, 0);
        checkOutput("mis memerr pre", MemErr, 0);
        tick();
        applyNop();
        #1;
        checkOutput("mis memerr", MemErr, 1);
        checkOutput("mis store req", dmem_req, 0);
        checkOutput("mis store we", dmem_we, 0);
        tick();

        $display("[TB] branch and flush");
        applyStimulus(32'h0, 32'h0, 5'd0, 4'b0100, 2'b00, 32'h40, 1'b1, 1'b0);
        tick();
        applyStimulus(32'h66, 32'h0, 5'd12, 4'b0100, 2'b01, 32'h80, 1'b1, 1'b1);
        #1;
        checkOutput("beq pcsrc", PCSrc, 1);
        checkOutput("beq target", BranchTarget, 32'h40);
        tick();
        applyNop();
        #1;
        checkOutput("flush pcsrc", PCSrc, 0);
        checkOutput("flush regwrite", RegWrite_inMEM, 0);
        tick();
        tick();

        $display("[TB] back-to-back loads");
        applyStimulus(32'h100, 32'h0, 5'd10, 4'b0001, 2'b11, 32'h0, 1'b0, 1'b0);
        expectWb(5'd10, 32'h1111);
        tick();
        applyStimulus(32'h104, 32'h0, 5'd11, 4'b0001, 2'b11, 32'h0, 1'b0, 1'b0);
        expectWb(5'd11, 32'h2222);
        dmem_rdata = 32'h1111;
        dmem_ready = 1'b1;
        #1;
        checkOutput("b2b first addr", dmem_addr, 32'h100);
        checkOutput("b2b first stall", Stall, 0);
        tick();
        applyNop();
        dmem_rdata = 32'h2222;
        #1;
        checkOutput("b2b second req", dmem_req, 1);
        checkOutput("b2b second addr", dmem_addr, 32'h104);
        tick();
        dmem_ready = 1'b0;
        tick();
        tick();

        checkOutput("scoreboard drained", sbQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage4.md
# stage4

Memory-access stage of the 5-stage MIPS pipeline. Holds the EX/MEM pipeline register fed by the execute stage and drives a variable-latency data-memory request/ready handshake. Stalls the front of the pipeline while an access is outstanding, resolves `beq`, and produces the MEM/WB register. It also supplies the `ALUop_inMEM` and `MUXop_inWB` forwarding values consumed by the execute stage.

## Interface
Parameters:
- `TIMEOUT`, default 15: maximum wait cycles for `dmem_ready` before an access is aborted.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; clears all state.
- `Result`  in  32  ALU result from EX; the memory address for loads and stores.
- `OutB`  in  32  forwarded rt value from EX; the store data.
- `WriteReg`  in  5  destination register from EX.
- `MEMReg`  in  4  MEM control: bit0 MemRead, bit1 MemWrite, bit2 Branch, bit3 reserved (ignored).
- `WBReg`  in  2  WB control: bit0 RegWrite, bit1 MemtoReg.
- `PCPlus4PlusOff`  in  32  branch target from EX.
- `Equal`  in  1  A==B compare from EX.
- `Flush`  in  1  loads a bubble into EX/MEM.
- `dmem_req`  out  1  access request.
- `dmem_we`  out  1  1 = store.
- `dmem_addr`  out  32  word address.
- `dmem_wdata`  out  32  store data.
- `dmem_rdata`  in  32  load data; valid with `dmem_ready`.
- `dmem_ready`  in  1  access complete.
- `Stall`  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- `ALUop_inMEM`  out  32  EX/MEM Result, used for forwarding.
- `RegWrite_inMEM`  out  1  EX/MEM RegWrite.
- `WriteReg_inMEM`  out  5  EX/MEM destination register.
- `PCSrc`  out  1  branch taken.
- `BranchTarget`  out  32  EX/MEM `PCPlus4PlusOff`.
- `MUXop_inWB`  out  32  MEM/WB writeback value.
- `RegWrite_inWB`  out  1  MEM/WB RegWrite.
- `WriteReg_inWB`  out  5  MEM/WB destination register.
- `MemErr`  out  1  sticky error flag: misaligned address or timeout.

## Operation
- **EX/MEM register update.**
  - Loads all EX inputs at the clock edge when `Stall`=0.
  - If `Flush`=1 and `Stall`=0, loads MEM=0 and WB=0 instead; data fields are don't-care.
  - Holds its value while `Stall`=1. `Stall` takes priority over `Flush`.
- **Memory operation.** A memop is an EX/MEM entry with MemRead or MemWrite set. If both bits are set, the entry is treated as a store.
- **FSM states.**
  - IDLE. A memop with an aligned address moves to WAIT; `dmem_req` is asserted combinationally in that same cycle.
  - WAIT. `dmem_req`=1, `dmem_we`=MemWrite, and address and data come from EX/MEM.
    - On `dmem_ready`=1: go to IDLE. Load data is captured into MEM/WB.
    - On wait count = TIMEOUT: go to IDLE, set `MemErr`, and use load data 0.
- **Stall.** `Stall` = memop and not (`dmem_req` and `dmem_ready`) and not aborted. A 1-cycle memory therefore causes zero stall cycles.
- **Misaligned access** (`Result[1:0]`≠0 on a memop):
  - no request is issued and no stall occurs;
  - `MemErr` is set;
  - a store is suppressed, and a load writes back 0.
- **MEM/WB register.**
  - Captures at the edge when `Stall`=0.
  - While `Stall`=1, captures a bubble (RegWrite=0).
  - `MUXop_inWB` = MemtoReg ? load data : ALU result.
- **Branch.** `PCSrc` = Branch and registered Equal, driven combinationally from EX/MEM. Branches are never memops.
- **Handshake rules.**
  - `dmem_ready` is ignored while `dmem_req`=0.
  - Address, data and `we` stay stable while `dmem_req`=1.
- **Reset.**
  - Clears every register, the FSM (to IDLE), `MemErr` and all outputs to 0.
  - Reset in the middle of WAIT drops `dmem_req` in the next cycle. A late `dmem_ready` is then ignored.

## Timing
- Latency:
  - EX inputs reach `ALUop_inMEM` one cycle after capture.
  - Writeback values reach `MUXop_inWB` two cycles after EX, plus N cycles of stall.
- An access with `dmem_ready` at wait cycle k (0 = first request cycle) stalls for k cycles.
- The wait counter is 4 bits for the default `TIMEOUT`. It resets when entering WAIT and saturates at abort.
- Back-to-back memops each start in the cycle immediately after the previous completion. There is no idle gap.
- `MemErr` is set on the edge following the fault and stays set until `reset`.

## Structure
- Shared package `mips_pkg`:
  - MEM and WB bit-index constants;
  - FSM state encoding (IDLE, WAIT);
  - the default `TIMEOUT`.
- One sub-module, `dmem_if`: the FSM, wait counter, request drive and stall/abort generation.
- Pipeline registers and branch logic live in the top level.

## Test plan
- **Load, zero-wait memory.** `lw` with addr 0x10 and `dmem_ready` in the same cycle → `Stall` never asserted; `MUXop_inWB` = `dmem_rdata` (0xDEADBEEF) two cycles after EX; `RegWrite_inWB`=1.
- **Store, 3-cycle wait.** `sw` with addr 0x20 and data 0x1234 → `dmem_req`/`dmem_we` held for 4 cycles with stable address and data; `Stall`=1 for 3 cycles; one bubble inserted into MEM/WB per stall cycle.
- **Timeout.** `lw` with `dmem_ready` held low → abort after 15 wait cycles; `MemErr`=1; write value 0; pipeline resumes.
- **Misaligned access.** `lw` with addr 0x22 → no `dmem_req`; `MemErr`=1; `MUXop_inWB`=0; no stall.
- **Branch and flush.** `beq` with Equal=1 and target 0x40 → `PCSrc`=1 and `BranchTarget`=0x40 for one cycle. `Flush`=1 on the following edge → EX/MEM holds a bubble.
- **Reset mid-wait.** `reset` asserted in cycle 2 of a WAIT → all outputs 0 and `dmem_req`=0 on the next cycle; `dmem_ready` pulsed afterwards has no effect.
